// File: rtl/fpacc_seq.sv
// Float32 stream accumulator: drives an external combinational adder and returns one total per packet.
// Optional sticky NaN tracking is enabled by defining FPACC_NAN_STICKY_EN.
module fpacc_seq #(
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic [31:0]        add_a,
  output logic [31:0]        add_b,
  input  logic [31:0]        add_s,
  output logic               sum_valid,
  input  logic               sum_ready,
  output logic [31:0]        sum_data,
  output logic [COUNT_W-1:0] sum_count,
  output logic               nan_seen
);

  typedef enum logic {StAcc, StHold} state_e;

  localparam logic [COUNT_W-1:0] CntMax = '1;

  state_e               state_q, state_d;
  logic [31:0]          acc_q, acc_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic                 first_q, first_d;
  logic                 accept;
  logic                 pkt_reset;

  assign accept    = (state_q == StAcc) && in_valid && !clear;
  assign pkt_reset = ((state_q == StAcc) && clear) || ((state_q == StHold) && sum_ready);

`ifdef FPACC_NAN_STICKY_EN
  logic nan_flag_q, nan_flag_d;

  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAcc;
      acc_q   <= 32'h0;
      cnt_q   <= '0;
      first_q <= 1'b1;
`ifdef FPACC_NAN_STICKY_EN
      nan_flag_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
`ifdef FPACC_NAN_STICKY_EN
      nan_flag_q <= nan_flag_d;
`endif
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc:   if (accept && in_last) state_d = StHold;
      StHold:  if (sum_ready) state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  always_comb begin
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    first_d = first_q;
`ifdef FPACC_NAN_STICKY_EN
    nan_flag_d = nan_flag_q;
`endif
    if (pkt_reset) begin
      acc_d   = 32'h0;
      cnt_d   = '0;
      first_d = 1'b1;
`ifdef FPACC_NAN_STICKY_EN
      nan_flag_d = 1'b0;
`endif
    end else if (accept) begin
      // The first element bypasses the adder so single-element packets are bit-exact.
      acc_d   = first_q ? in_data : add_s;
      first_d = 1'b0;
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
`ifdef FPACC_NAN_STICKY_EN
      nan_flag_d = nan_flag_q | is_nan(in_data) | is_nan(add_s);
      if (nan_flag_d) acc_d = 32'h7F80_0001;
`endif
    end
  end

  // Outputs
  always_comb begin
    in_ready  = (state_q == StAcc) && !clear;
    sum_valid = (state_q == StHold);
    add_a     = acc_q;
    add_b     = in_data;
    sum_data  = acc_q;
    sum_count = cnt_q;
`ifdef FPACC_NAN_STICKY_EN
    nan_seen  = nan_flag_q;
`else
    nan_seen  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_fpacc_seq.sv
// Directed bench for fpacc_seq with a real-valued behavioural adder wired to the add_* ports.
module tb_fpacc_seq;

  localparam int unsigned CW = 2;

  logic          clk;
  logic          rst_n;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_data;
  logic          in_last;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic [31:0]   add_s;
  logic          sum_valid;
  logic          sum_ready;
  logic [31:0]   sum_data;
  logic [CW-1:0] sum_count;
  logic          nan_seen;

  int n_chk = 0;
  int n_bad = 0;

  fpacc_seq #(.COUNT_W(CW)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_s     (add_s),
    .sum_valid (sum_valid),
    .sum_ready (sum_ready),
    .sum_data  (sum_data),
    .sum_count (sum_count),
    .nan_seen  (nan_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    logic [10:0] e;
    if (f[30:23] == 8'd0) return 0.0;
    e = {3'b000, f[30:23]} + 11'd896;
    d = {f[31], e, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    logic [7:0]  e8;
    if (r == 0.0) return 32'h0;
    d  = $realtobits(r);
    e  = d[62:52] - 11'd896;
    e8 = e[7:0];
    return {d[63], e8, d[51:29]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) return 32'h7FC0_0000;
    return r2f(f2r(a) + f2r(b));
  endfunction

  always_comb add_s = fadd(add_a, add_b);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [31:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [31:0] hold_data;

  initial begin
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    in_last   = 1'b0;
    sum_ready = 1'b0;
    #3;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_sum_valid", 32'(sum_valid), 32'd0);
    check_eq("rst_sum_data", sum_data, 32'h0);
    check_eq("rst_sum_count", 32'(sum_count), 32'd0);
    check_eq("rst_nan_seen", 32'(nan_seen), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Single element, consumer ready
    sum_ready = 1'b1;
    beat(32'h3F80_0000, 1'b1);
    check_eq("one_valid", 32'(sum_valid), 32'd1);
    check_eq("one_data", sum_data, 32'h3F80_0000);
    check_eq("one_count", 32'(sum_count), 32'd1);
    check_eq("one_in_ready", 32'(in_ready), 32'd0);
    step();
    check_eq("one_back_valid", 32'(sum_valid), 32'd0);
    check_eq("one_back_ready", 32'(in_ready), 32'd1);
    check_eq("one_back_data", sum_data, 32'h0);

    // Three elements, then backpressure in HOLD
    sum_ready = 1'b0;
    beat(32'h3F80_0000, 1'b0);
    beat(32'h4000_0000, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'h3F00_0000;
    in_last  = 1'b1;
    #1;
    check_eq("three_add_a", add_a, 32'h4040_0000);
    check_eq("three_add_b", add_b, 32'h3F00_0000);
    step();
    check_eq("three_valid", 32'(sum_valid), 32'd1);
    check_eq("three_data", sum_data, 32'h4060_0000);
    check_eq("three_count", 32'(sum_count), 32'd3);
    in_data = 32'h4000_0000;
    for (int i = 0; i < 5; i++) begin
      step();
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_valid", 32'(sum_valid), 32'd1);
      check_eq("hold_data", sum_data, 32'h4060_0000);
      check_eq("hold_count", 32'(sum_count), 32'd3);
    end
    sum_ready = 1'b1;
    step();
    check_eq("after_hs_ready", 32'(in_ready), 32'd1);
    check_eq("after_hs_data", sum_data, 32'h0);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    check_eq("next_pkt_data", sum_data, 32'h4000_0000);
    check_eq("next_pkt_count", 32'(sum_count), 32'd1);
    step();

    // Clear mid-packet with a simultaneous valid word
    beat(32'h3F80_0000, 1'b0);
    beat(32'h4000_0000, 1'b0);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h4080_0000;
    #1;
    check_eq("clear_in_ready", 32'(in_ready), 32'd0);
    step();
    clear    = 1'b0;
    in_valid = 1'b0;
    check_eq("clear_data", sum_data, 32'h0);
    check_eq("clear_count", 32'(sum_count), 32'd0);
    check_eq("clear_valid", 32'(sum_valid), 32'd0);
    beat(32'h3F80_0000, 1'b1);
    check_eq("post_clear_data", sum_data, 32'h3F80_0000);
    check_eq("post_clear_count", 32'(sum_count), 32'd1);
    check_eq("post_clear_nan", 32'(nan_seen), 32'd0);
    step();

    // Count saturation at 2^CW-1
    for (int i = 0; i < 5; i++) beat(32'h0, (i == 4) ? 1'b1 : 1'b0);
    check_eq("sat_valid", 32'(sum_valid), 32'd1);
    check_eq("sat_count", 32'(sum_count), 32'd3);
    check_eq("sat_data", sum_data, 32'h0);
    step();

`ifdef FPACC_NAN_STICKY_EN
    beat(32'h3F80_0000, 1'b0);
    beat(32'h7FC0_0000, 1'b0);
    beat(32'h4000_0000, 1'b1);
    check_eq("nan_data", sum_data, 32'h7F80_0001);
    check_eq("nan_seen", 32'(nan_seen), 32'd1);
    step();
    beat(32'h3F80_0000, 1'b1);
    check_eq("nan_clr_seen", 32'(nan_seen), 32'd0);
    check_eq("nan_clr_data", sum_data, 32'h3F80_0000);
    step();
`endif

    // Async reset mid-packet and during HOLD
    beat(32'h3F80_0000, 1'b0);
    beat(32'h4000_0000, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_acc_data", sum_data, 32'h0);
    check_eq("arst_acc_count", 32'(sum_count), 32'd0);
    check_eq("arst_acc_ready", 32'(in_ready), 32'd1);
    step();
    rst_n     = 1'b1;
    sum_ready = 1'b0;
    beat(32'h4000_0000, 1'b1);
    hold_data = sum_data;
    check_eq("pre_arst_hold", 32'(sum_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_hold_valid", 32'(sum_valid), 32'd0);
    check_eq("arst_hold_data", sum_data, 32'h0);
    check_eq("arst_hold_nan", 32'(nan_seen), 32'd0);
    step();
    rst_n     = 1'b1;
    sum_ready = 1'b1;
    beat(32'h3F80_0000, 1'b1);
    check_eq("post_arst_data", sum_data, 32'h3F80_0000);
    check_eq("post_arst_count", 32'(sum_count), 32'd1);
    check_eq("pre_arst_total", hold_data, 32'h4000_0000);
    step();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/fpacc_seq.md
# fpacc_seq

Sequential float32 stream accumulator that sits directly upstream of the combinational single-precision adder. It drives the adder's two operand buses and captures its sum, turning a valid/ready stream of IEEE-754 words into one running total per packet. The total is presented on an output handshake together with an element count. The adder itself stays outside this block and is wired to the `add_*` ports.

## Interface
Parameters:
- `COUNT_W`, default 16: width of the element counter.

Ports:
- `clk`, input, 1: the single clock; all state changes on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `clear`, input, 1: synchronous packet abort; honoured only in ACC.
- `in_valid`, input, 1: input word valid.
- `in_ready`, output, 1: block accepts the input word this cycle.
- `in_data`, input, 32: float32 element.
- `in_last`, input, 1: marks the final element of the packet.
- `add_a`, output, 32: adder operand a, always equal to `acc`.
- `add_b`, output, 32: adder operand b, always equal to `in_data`.
- `add_s`, input, 32: adder sum, combinational from `add_a`/`add_b`.
- `sum_valid`, output, 1: packet total available.
- `sum_ready`, input, 1: consumer takes the total.
- `sum_data`, output, 32: packet total.
- `sum_count`, output, COUNT_W: number of elements in the packet, saturating.
- `nan_seen`, output, 1: a NaN entered the current packet (see Configuration).

## Operation
- Internal state:
  - `acc[31:0]`: running total.
  - `first`: set when no element has been absorbed yet.
  - `cnt[COUNT_W-1:0]`: element counter.
  - `nan_flag`: NaN seen in the current packet.
  - FSM with two states, ACC and HOLD.
- ACC state:
  - `in_ready = !clear`.
  - An input is accepted when `in_valid & in_ready`.
- Accepted element:
  - If `first`: `acc <= in_data`. This bypasses the adder, so a one-element packet returns its input bit-exactly.
  - Otherwise: `acc <= add_s`.
  - `first <= 0`.
  - `cnt <= cnt + 1`; the count saturates at 2^COUNT_W−1 and never wraps.
  - If `in_last`: go to HOLD.
- `clear` in ACC:
  - `acc <= 0`, `cnt <= 0`, `first <= 1`, `nan_flag <= 0`.
  - Any simultaneous `in_valid` word is not accepted, because `in_ready` is 0.
- HOLD state:
  - `in_ready = 0`, `sum_valid = 1`.
  - `sum_data = acc`, `sum_count = cnt`; both are held stable until the handshake.
  - `clear` is ignored.
  - On `sum_valid & sum_ready`: go to ACC with `acc <= 0`, `cnt <= 0`, `first <= 1`, `nan_flag <= 0`.
- Outputs outside HOLD:
  - `sum_valid = 0`.
  - `sum_data` and `sum_count` still show `acc` and `cnt`; consumers must gate on `sum_valid`.
- The adder ports are purely combinational pass-throughs. The block adds no rounding or special-value handling of its own, except as described in Configuration.

## Timing
- Reset values (on `rst_n` low, immediately, asynchronously):
  - state ACC, `acc = 0x00000000`, `cnt = 0`, `first = 1`, `nan_flag = 0`.
  - `in_ready = 1`, `sum_valid = 0`, `sum_data = 0`, `sum_count = 0`, `nan_seen = 0`.
- Throughput: one element per cycle in ACC.
- Latency: `sum_valid` rises on the cycle after `in_last` is accepted.
- `in_ready` is low for the whole HOLD period. The earliest next element is accepted in the cycle after the output handshake, so there is one bubble minimum.
- A `sum_ready` that is already high when HOLD is entered completes the handshake in the first HOLD cycle.
- Reset during ACC or HOLD discards the partial or pending total; no output is produced for it.
- Paths `add_s`→`acc` and `in_data`→`add_b`: the full adder delay must fit in one `clk` period.

## Configuration
- Macro: `FPACC_NAN_STICKY_EN`.
- Defined:
  - Per accepted element, `nan_flag` is set if the element has exp==0xFF with a nonzero fraction, or if the adder result `add_s` does.
  - While `nan_flag` is set, the update is `acc <= 0x7F800001` regardless of later inputs.
  - `nan_seen = nan_flag`.
  - `nan_flag` clears with the packet, i.e. on `clear`, the output handshake, or reset.
- Not defined:
  - `nan_flag` logic is absent and `nan_seen` is tied to 0.
  - `acc` follows `add_s` unconditionally.

## Test plan
- Single-element packet 0x3F800000 (1.0) with `in_last`, `sum_ready=1` → next cycle `sum_valid=1`, `sum_data=0x3F800000`, `sum_count=1`; back to ACC the cycle after.
- Packet 1.0, 2.0, 0.5 (0x3F800000, 0x40000000, 0x3F000000), bench adder model → `sum_data=0x40600000` (3.5), `sum_count=3`; `add_a` on the third beat is 0x40400000.
- `sum_ready` held low for 5 cycles in HOLD while `in_valid=1` → `in_ready=0` and `sum_data`/`sum_count` stable throughout; the next packet starts only after the handshake.
- `clear` asserted together with `in_valid` mid-packet (after 2.0) → that word is not accepted; the next packet of 1.0 alone returns 0x3F800000, `sum_count=1`.
- With `FPACC_NAN_STICKY_EN`: packet 1.0, 0x7FC00000, 2.0 → `sum_data=0x7F800001`, `nan_seen=1`; the following packet of 1.0 gives `nan_seen=0`.
- `COUNT_W=2`, packet of 5 elements of 0x00000000 → `sum_count=3` (saturated); `rst_n` pulsed low mid-packet → all outputs return to reset values immediately.
